// File: rtl/sr_btn_ctrl.sv
// Push-button front end for an SR stage: synchronises and debounces SET/RESET buttons and
// turns each debounced press into a one-cycle s or r command, with conflict detection and lockout.
module sr_btn_ctrl #(
  parameter int unsigned DEB_CNT = 4,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned LOCK    = 8,
  parameter int unsigned LOCK_W  = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic btn_set,
  input  logic btn_rst,
  output logic s,
  output logic r,
  output logic conflict,
  output logic busy
);

  typedef enum logic {StIdle, StHold} state_e;

  localparam logic [CNT_W-1:0]  DebLast  = CNT_W'(DEB_CNT - 1);
  localparam logic [LOCK_W-1:0] LockLoad = LOCK_W'(LOCK);

  // Channel 0 is SET, channel 1 is RESET.
  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] stb_q, stb_d;
  logic [1:0] stb_dly_q;
  logic [1:0] press;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  state_e            state_q, state_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic              s_q, s_d;
  logic              r_q, r_d;
  logic              conflict_q, conflict_d;
  logic              pulse;

  assign btn_raw = {btn_rst, btn_set};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stb_d[i] = stb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != stb_q[i]) begin
        if (cnt_q[i] == DebLast) begin
          stb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = stb_q & ~stb_dly_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stb_q     <= '0;
      stb_dly_q <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      stb_q     <= stb_d;
      stb_dly_q <= stb_q;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
    end
  end

  // The HOLD state also covers the command cycle itself; the countdown starts after it.
  assign pulse = s_q | r_q | conflict_q;

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    conflict_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press != 2'b00) begin
          s_d        = (press == 2'b01);
          r_d        = (press == 2'b10);
          conflict_d = (press == 2'b11);
          if (LOCK != 0) begin
            state_d = StHold;
            lock_d  = LockLoad;
          end
        end
      end
      StHold: begin
        if (!pulse) begin
          if (lock_q <= LOCK_W'(1)) begin
            state_d = StIdle;
            lock_d  = '0;
          end else begin
            lock_d = lock_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        lock_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      lock_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;
  assign busy     = (state_q == StHold) & ~pulse;

endmodule

// File: tb/tb_sr_btn_ctrl.sv
// Directed bench for sr_btn_ctrl with DEB_CNT=4, LOCK=8: command lands after edge 6,
// busy covers edges 7..14 relative to the first edge sampling the button high.
module tb_sr_btn_ctrl;

  logic clk = 1'b0;
  logic n_rst;
  logic btn_set;
  logic btn_rst;
  logic s, r, conflict, busy;

  int checks = 0;
  int errors = 0;

  sr_btn_ctrl #(
    .DEB_CNT(4),
    .CNT_W  (5),
    .LOCK   (8),
    .LOCK_W (4)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .btn_set (btn_set),
    .btn_rst (btn_rst),
    .s       (s),
    .r       (r),
    .conflict(conflict),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input int k, input logic es, input logic er,
                     input logic ec, input logic eb);
    chk($sformatf("%s s k=%0d", tag, k), s, es);
    chk($sformatf("%s r k=%0d", tag, k), r, er);
    chk($sformatf("%s conflict k=%0d", tag, k), conflict, ec);
    chk($sformatf("%s busy k=%0d", tag, k), busy, eb);
    chk($sformatf("%s s&r k=%0d", tag, k), s & r, 1'b0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      cyc(tag, k, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    n_rst   = 1'b0;
    btn_set = 1'b0;
    btn_rst = 1'b0;
    #1;
    cyc("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_rst = 1'b1;
    idle("post_reset", 5);

    // Clean SET press held 20 cycles.
    btn_set = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      cyc("set_clean", k, k == 6, 1'b0, 1'b0, (k >= 7) && (k <= 14));
    end
    btn_set = 1'b0;
    idle("set_release", 20);

    // 3-cycle RESET glitch is rejected.
    btn_rst = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k == 2) btn_rst = 1'b0;
      cyc("rst_glitch", k, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 10-cycle RESET press produces one r.
    btn_rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 9) btn_rst = 1'b0;
      cyc("rst_10", k, 1'b0, k == 6, 1'b0, (k >= 7) && (k <= 14));
    end
    idle("rst_release", 20);

    // Bouncing SET: sampled 1,0,1,0 then held from edge 4; s lands after edge 10.
    btn_set = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      btn_set = (k == 1) || (k >= 3);
      cyc("bounce", k, k == 10, 1'b0, 1'b0, (k >= 11) && (k <= 18));
    end
    btn_set = 1'b0;
    idle("bounce_release", 20);

    // Simultaneous press reports a conflict.
    btn_set = 1'b1;
    btn_rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      cyc("both", k, 1'b0, 1'b0, k == 6, (k >= 7) && (k <= 14));
    end
    btn_set = 1'b0;
    btn_rst = 1'b0;
    idle("both_release", 20);

    // RESET press lands at edge 10, inside HOLD: dropped.
    btn_set = 1'b1;
    for (int k = 0; k < 26; k++) begin
      tick();
      if (k == 3) btn_rst = 1'b1;
      if (k == 16) btn_rst = 1'b0;
      if (k == 19) btn_set = 1'b0;
      cyc("drop", k, k == 6, 1'b0, 1'b0, (k >= 7) && (k <= 14));
    end
    idle("drop_idle", 20);
    btn_rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      cyc("repress", k, 1'b0, k == 6, 1'b0, (k >= 7) && (k <= 14));
    end
    btn_rst = 1'b0;
    idle("repress_release", 20);

    // Reset asserted while r is high clears it and the pending HOLD at once.
    btn_rst = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      cyc("midreset", k, 1'b0, k == 6, 1'b0, 1'b0);
    end
    n_rst = 1'b0;
    #1;
    cyc("midreset_async", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    btn_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    idle("midreset_after", 20);

    // SET held across a 2-cycle reset at cycle 20: fresh press after release.
    btn_set = 1'b1;
    for (int k = 0; k < 21; k++) begin
      tick();
      cyc("held_pre", k, k == 6, 1'b0, 1'b0, (k >= 7) && (k <= 14));
    end
    n_rst = 1'b0;
    #1;
    cyc("held_async", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      cyc("held_post", k, k == 6, 1'b0, 1'b0, (k >= 7) && (k <= 14));
    end
    btn_set = 1'b0;
    idle("final", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_btn_ctrl.md
Name: sr_btn_ctrl

Overview:
- Front-end command stage that directly feeds the SR flip-flop's s/r inputs.
- Takes two raw, asynchronous push-button inputs (SET, RESET).
- Synchronizes and debounces each input, then converts each debounced press into a single-cycle s or r pulse.
- Guarantees s and r are never high together. A simultaneous press is reported as a conflict. A lockout window after each command rejects bounce and double-hits.

Parameters:
- DEB_CNT, 4: consecutive cycles a synchronized input must differ from its debounced state before that state flips. Legal range 1..2^CNT_W-1.
- CNT_W, 5: width of each debounce counter.
- LOCK, 8: cycles the block stays in HOLD after an emitted pulse or conflict. 0 = no lockout.
- LOCK_W, 4: width of the lockout counter. LOCK must be <= 2^LOCK_W-1.

Ports:
- clk, input, 1: system clock, rising edge.
- n_rst, input, 1: reset, asynchronous, active-low.
- btn_set, input, 1: raw SET button, active-high, asynchronous to clk.
- btn_rst, input, 1: raw RESET button, active-high, asynchronous to clk.
- s, output, 1: registered one-cycle set command to the SR stage.
- r, output, 1: registered one-cycle reset command to the SR stage.
- conflict, output, 1: registered one-cycle flag; both presses were detected in the same cycle.
- busy, output, 1: high while in HOLD (lockout active).

Behaviour:
- Reset (n_rst=0, asynchronous):
  - Outputs: s=0, r=0, conflict=0, busy=0.
  - Internal: sync flops=0, debounced states=0, edge-history flops=0, debounce counters=0, lockout counter=0, FSM=IDLE.
- Synchronizer: 2-flop chain per button. No logic between the two flops.
- Debounce, per channel (sync2 = synchronized input, stb = debounced state):
  - If sync2 == stb: counter clears to 0.
  - Otherwise counter increments. On the edge where counter == DEB_CNT-1 and sync2 still != stb: stb <= sync2 and counter <= 0.
  - Any return of sync2 to stb before that point clears the counter. Glitches shorter than DEB_CNT cycles are rejected.
- Press event:
  - press = stb & ~stb_d, where stb_d is stb delayed one cycle.
  - Releases (falling edges) generate nothing.
  - A held button produces exactly one event (no auto-repeat).
- Latency: edge 0 is the first edge sampling the raw input high.
  - sync2=1 after edge 1.
  - stb=1 after edge DEB_CNT+1.
  - s (or r) high after edge DEB_CNT+2, low after edge DEB_CNT+3.
- FSM, states IDLE and HOLD:
  - IDLE, set_press only: s=1 for 1 cycle, go to HOLD.
  - IDLE, rst_press only: r=1 for 1 cycle, go to HOLD.
  - IDLE, both presses in the same cycle: s=0, r=0, conflict=1 for 1 cycle, go to HOLD.
  - IDLE, no press: stay in IDLE, outputs 0.
  - HOLD: lockout counter loads LOCK on entry and decrements each cycle. Return to IDLE on the edge where it reaches 0, so busy is high for exactly LOCK cycles starting the cycle after the pulse.
  - LOCK=0: skip HOLD and stay in IDLE. Back-to-back events are then accepted on consecutive cycles.
- Press events that occur during HOLD are dropped, not queued. Their edge is consumed, so a button still held when HOLD ends does not fire.
- Invariant: s & r == 0 in every cycle. s, r and conflict are mutually exclusive.
- Reset mid-operation: all state clears immediately, including any in-flight pulse or HOLD. A button held across reset release is seen as a fresh press after the normal debounce latency (stb restarts at 0).

Test Plan:
- Parameters DEB_CNT=4, LOCK=8. Raise btn_set cleanly and hold for 20 cycles -> s=1 only in the cycle after edge 6. r=0 and conflict=0 throughout. busy=1 for 8 cycles starting the cycle after the s pulse.
- btn_rst high for 3 cycles then low (glitch shorter than DEB_CNT) -> no r pulse, busy stays 0. Repeat with 10 cycles high -> one r pulse after edge 6.
- btn_set bounces 1,0,1,0 on alternate cycles, then held high -> exactly one s pulse, occurring DEB_CNT+2 edges after the last rising bounce edge.
- btn_set and btn_rst rise on the same edge -> conflict=1 for one cycle after edge 6. s and r never high. busy=1 for the next 8 cycles.
- s pulse fires, then btn_rst is pressed so that its press event lands 3 cycles into HOLD -> no r pulse, event dropped. Release and re-press btn_rst after HOLD ends -> one r pulse.
- btn_set held; n_rst pulsed low for 2 cycles at cycle 20 -> all outputs 0 immediately. After n_rst rises, s pulses once, DEB_CNT+2 edges after the first edge with n_rst high.
